// File: rtl/plat_arb_pkg.sv
// rtl/plat_arb_pkg.sv - shared types and constants for the platform table arbiter
//
// Purpose: state encoding, requester id constants and generation tag width
//          used by plat_table_arbiter and plat_abs_pos.
// Ports:   none (package).

package plat_arb_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    SERVE  = 1'b1
  } arb_state_e;

  localparam logic REQ_PHY = 1'b0;
  localparam logic REQ_RND = 1'b1;

  localparam int GEN_WIDTH = 4;

endpackage

// File: rtl/plat_abs_pos.sv
// rtl/plat_abs_pos.sv - block-relative to absolute world y conversion
//
// Purpose: abs_y = camera_y*BLOCK_WIDTH + rel_y, wrapped to PHY_WIDTH bits,
//          forced to zero for an out-of-range (err) lookup. Purely combinational;
//          the caller registers the result.
// Ports:
//   camera_y  in   CAMERA_WIDTH  block index the entry was read under
//   rel_y     in   PHY_WIDTH     block-relative y
//   err       in   1             lookup was out of range
//   abs_y     out  PHY_WIDTH     absolute world y

module plat_abs_pos
  import plat_arb_pkg::*;
#(
  parameter int PHY_WIDTH    = 16,
  parameter int CAMERA_WIDTH = 6,
  parameter int BLOCK_WIDTH  = 480
) (
  input  logic [CAMERA_WIDTH-1:0] camera_y,
  input  logic [PHY_WIDTH-1:0]    rel_y,
  input  logic                    err,
  output logic [PHY_WIDTH-1:0]    abs_y
);

  logic [PHY_WIDTH-1:0] block_base;

  // Doing the arithmetic at PHY_WIDTH gives the mod 2^PHY_WIDTH wrap for free.
  assign block_base = PHY_WIDTH'(camera_y) * PHY_WIDTH'(BLOCK_WIDTH);
  assign abs_y      = err ? '0 : (block_base + rel_y);

endmodule

// File: rtl/plat_table_arbiter.sv
// rtl/plat_table_arbiter.sv - physics/renderer arbiter for the current block's platform table
//
// Purpose: grants one of two requesters per cycle, looks up one platform entry,
//          and returns a tagged absolute-coordinate response two cycles later.
//          Grants are blocked for SETTLE_CYCLES cycles after reset and after
//          every block_switch so nobody reads a table that is being replaced.
// Config:  PLAT_ARB_FIXED_PRIO_EN - physics always wins ties (no pointer);
//          undefined gives round-robin on a last-granted pointer.
// Ports:
//   sys_clk, sys_rst                 clock, synchronous active-high reset
//   block_switch                     one-cycle pulse, table/camera_y change
//   camera_y                         current block index
//   plat_relative_x/_y, plat_len     packed platform table
//   phy_req/phy_idx, rnd_req/rnd_idx requests (held until granted)
//   phy_gnt, rnd_gnt                 combinational grants
//   rsp_valid, rsp_id, rsp_err       response strobe, requester, bad index
//   rsp_abs_x, rsp_abs_y, rsp_len    platform data
//   rsp_gen                          block generation the data came from

module plat_table_arbiter
  import plat_arb_pkg::*;
#(
  parameter int PLATFORM_NUM_PER_BLOCK = 7,
  parameter int PHY_WIDTH              = 16,
  parameter int BLOCK_LEN_WIDTH        = 4,
  parameter int CAMERA_WIDTH           = 6,
  parameter int BLOCK_WIDTH            = 480,
  parameter int IDX_WIDTH              = 3,
  parameter int SETTLE_CYCLES          = 2
) (
  input  logic                                        sys_clk,
  input  logic                                        sys_rst,
  input  logic                                        block_switch,
  input  logic [CAMERA_WIDTH-1:0]                     camera_y,
  input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0] plat_relative_x,
  input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0] plat_relative_y,
  input  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
  input  logic                                        phy_req,
  input  logic [IDX_WIDTH-1:0]                        phy_idx,
  input  logic                                        rnd_req,
  input  logic [IDX_WIDTH-1:0]                        rnd_idx,
  output logic                                        phy_gnt,
  output logic                                        rnd_gnt,
  output logic                                        rsp_valid,
  output logic                                        rsp_id,
  output logic                                        rsp_err,
  output logic [PHY_WIDTH-1:0]                        rsp_abs_x,
  output logic [PHY_WIDTH-1:0]                        rsp_abs_y,
  output logic [BLOCK_LEN_WIDTH-1:0]                  rsp_len,
  output logic [GEN_WIDTH-1:0]                        rsp_gen
);

  localparam int CNT_WIDTH = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  // ---------------------------------------------------------------- settle FSM
  arb_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= SETTLE;
      cnt_q   <= CNT_WIDTH'(SETTLE_CYCLES);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter holds the number of blocked cycles still to come, so SETTLE
  // lasts exactly SETTLE_CYCLES cycles after the cycle that loaded it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (block_switch) begin
      state_d = SETTLE;
      cnt_d   = CNT_WIDTH'(SETTLE_CYCLES);
    end else if (state_q == SETTLE) begin
      if (cnt_q <= CNT_WIDTH'(1)) begin
        state_d = SERVE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------- grants
  logic serve_ok;
  assign serve_ok = !sys_rst && (state_q == SERVE) && !block_switch;

`ifdef PLAT_ARB_FIXED_PRIO_EN
  assign phy_gnt = serve_ok && phy_req;
  assign rnd_gnt = serve_ok && rnd_req && !phy_req;
`else
  logic last_q;

  // On a tie the requester that was not granted last wins.
  assign phy_gnt = serve_ok && phy_req && (!rnd_req || (last_q == REQ_RND));
  assign rnd_gnt = serve_ok && rnd_req && (!phy_req || (last_q == REQ_PHY));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      last_q <= REQ_RND;
    end else if (phy_gnt) begin
      last_q <= REQ_PHY;
    end else if (rnd_gnt) begin
      last_q <= REQ_RND;
    end
  end
`endif

  logic                 xfer;
  logic                 xfer_id;
  logic [IDX_WIDTH-1:0] sel_idx;

  assign xfer    = phy_gnt || rnd_gnt;
  assign xfer_id = phy_gnt ? REQ_PHY : REQ_RND;
  assign sel_idx = phy_gnt ? phy_idx : rnd_idx;

  // ---------------------------------------------------------------- table lookup
  logic                       lk_err;
  logic [PHY_WIDTH-1:0]       lk_x, lk_y;
  logic [BLOCK_LEN_WIDTH-1:0] lk_len;

  // An index matching no entry leaves err set and all data zero.
  always_comb begin
    lk_err = 1'b1;
    lk_x   = '0;
    lk_y   = '0;
    lk_len = '0;
    for (int i = 0; i < PLATFORM_NUM_PER_BLOCK; i++) begin
      if (sel_idx == IDX_WIDTH'(i)) begin
        lk_err = 1'b0;
        lk_x   = plat_relative_x[i*PHY_WIDTH +: PHY_WIDTH];
        lk_y   = plat_relative_y[i*PHY_WIDTH +: PHY_WIDTH];
        lk_len = plat_len[i*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------- generation tag
  logic [GEN_WIDTH-1:0] gen_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      gen_q <= '0;
    end else if (block_switch) begin
      gen_q <= gen_q + GEN_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic                       s1_valid;
  logic                       s1_id;
  logic                       s1_err;
  logic [PHY_WIDTH-1:0]       s1_x, s1_y;
  logic [BLOCK_LEN_WIDTH-1:0] s1_len;
  logic [CAMERA_WIDTH-1:0]    s1_cam;
  logic [GEN_WIDTH-1:0]       s1_gen;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_err   <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_len   <= '0;
      s1_cam   <= '0;
      s1_gen   <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_id  <= xfer_id;
        s1_err <= lk_err;
        s1_x   <= lk_x;
        s1_y   <= lk_y;
        s1_len <= lk_len;
        s1_cam <= camera_y;
        s1_gen <= gen_q;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [PHY_WIDTH-1:0] abs_y_d;

  plat_abs_pos #(
    .PHY_WIDTH    (PHY_WIDTH),
    .CAMERA_WIDTH (CAMERA_WIDTH),
    .BLOCK_WIDTH  (BLOCK_WIDTH)
  ) u_abs_pos (
    .camera_y (s1_cam),
    .rel_y    (s1_y),
    .err      (s1_err),
    .abs_y    (abs_y_d)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_abs_x <= '0;
      rsp_abs_y <= '0;
      rsp_len   <= '0;
      rsp_gen   <= '0;
    end else begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id    <= s1_id;
        rsp_err   <= s1_err;
        rsp_abs_x <= s1_x;
        rsp_abs_y <= abs_y_d;
        rsp_len   <= s1_len;
        rsp_gen   <= s1_gen;
      end
    end
  end

endmodule

// File: doc/plat_table_arbiter.md
# plat_table_arbiter

Arbitrates the single platform table of the current block between the physics engine and the renderer. Each granted request fetches one platform entry, converts its block-relative y into an absolute world y, and returns a tagged response two cycles later. On every block switch the arbiter stops granting for a fixed settle window so no requester reads a half-updated table. It sits between the block generator and its two consumers.

## Interface
- PLATFORM_NUM_PER_BLOCK, 7, platforms per block (table depth)
- PHY_WIDTH, 16, coordinate width
- BLOCK_LEN_WIDTH, 4, platform length field width
- CAMERA_WIDTH, 6, block index width
- BLOCK_WIDTH, 480, block height in world units
- IDX_WIDTH, 3, request index width
- SETTLE_CYCLES, 2, grant-blocking cycles after a block switch (must be ≥1)

Ports:
- sys_clk  in  1  the single clock
- sys_rst  in  1  synchronous, active-high reset
- block_switch  in  1  one-cycle pulse: the table and camera_y change
- camera_y  in  CAMERA_WIDTH  current block index
- plat_relative_x  in  PLATFORM_NUM_PER_BLOCK*PHY_WIDTH  packed table x
- plat_relative_y  in  PLATFORM_NUM_PER_BLOCK*PHY_WIDTH  packed table y
- plat_len  in  PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH  packed lengths
- phy_req, phy_idx  in  1, IDX_WIDTH  physics request and platform index
- rnd_req, rnd_idx  in  1, IDX_WIDTH  renderer request and platform index
- phy_gnt, rnd_gnt  out  1  combinational grants
- rsp_valid  out  1  response strobe
- rsp_id  out  1  0 = physics, 1 = renderer
- rsp_err  out  1  requested index ≥ PLATFORM_NUM_PER_BLOCK
- rsp_abs_x, rsp_abs_y  out  PHY_WIDTH  absolute platform coordinates
- rsp_len  out  BLOCK_LEN_WIDTH  platform length
- rsp_gen  out  4  block generation tag of the data

## Operation
- States: SETTLE, SERVE.
  - Reset enters SETTLE with the settle counter set to SETTLE_CYCLES.
  - SETTLE counts down to 0, then moves to SERVE.
  - In SERVE, a block_switch reloads the counter and returns to SETTLE.
  - A block_switch seen while in SETTLE also reloads the counter.
- Grants:
  - Only in SERVE, and never in a cycle where block_switch=1.
  - At most one grant per cycle.
  - A transfer is req&&gnt.
  - A requester holds req and idx stable until it sees gnt.
- Arbitration is round-robin on a last-granted pointer.
  - If only one requester is active, it wins.
  - If both are active, the one not granted last wins.
  - Reset value of the pointer is renderer, so physics wins the first tie.
- Stage 1 (register on transfer):
  - Latch rel_x, rel_y, len and the error flag for the index.
  - Latch id, camera_y and gen.
  - For out-of-range indices, latch x=y=len=0 and err=1.
- Stage 2 (register):
  - rsp_abs_x = rel_x.
  - rsp_abs_y = camera_y*BLOCK_WIDTH + rel_y, truncated to PHY_WIDTH (mod 2^PHY_WIDTH).
  - If err=1, rsp_abs_y = 0.
  - rsp_valid=1 for exactly one cycle.
- gen is a 4-bit counter incremented on each block_switch; it wraps 15→0.
- In-flight transfers complete with their latched data and latched gen, even across a block_switch.
- Reset mid-operation discards all in-flight transfers: no rsp_valid is produced for them.

## Timing
- Reset values:
  - gnt = 0, rsp_valid = 0, all rsp_* = 0.
  - gen = 0, state SETTLE, pointer = renderer.
- Latency: a transfer in cycle T gives rsp_valid in cycle T+2.
- Throughput: one transfer per cycle, pipelined back-to-back.
- After a block_switch pulse in cycle S:
  - No grant in cycles S through S+SETTLE_CYCLES.
  - The first possible grant is in cycle S+SETTLE_CYCLES+1.
- After reset is released, the first grant is in cycle SETTLE_CYCLES+1.
- gen increments at the edge ending cycle S. A transfer in cycle S cannot occur.

## Configuration
- PLAT_ARB_FIXED_PRIO_EN
  - Defined: physics always wins when both request. The pointer is removed and the renderer can starve.
  - Undefined (default): round-robin as described in Operation.

## Structure
- Package plat_arb_pkg holds:
  - state enum (SETTLE, SERVE)
  - REQ_PHY/REQ_RND id constants
  - GEN_WIDTH=4
- Sub-module plat_abs_pos holds the stage-2 computation: the camera_y*BLOCK_WIDTH multiply-add, truncation and err zeroing.

## Test plan
- Reset, then phy_req=1 idx=2 with camera_y=2 and rel_y[2]=150, rel_x[2]=370:
  - phy_gnt in cycle 3.
  - rsp_valid two cycles later with rsp_abs_y=1110, rsp_abs_x=370, rsp_id=0.
- Both requesters hold req for 4 cycles:
  - Grants alternate phy, rnd, phy, rnd.
  - With PLAT_ARB_FIXED_PRIO_EN defined: phy on all four, rnd none.
- block_switch pulse while requests are held:
  - No grants for 3 cycles (SETTLE_CYCLES=2).
  - An in-flight response still carries the old gen.
  - The next response carries gen+1.
- rnd_idx=7: response has rsp_err=1, rsp_len=0, rsp_abs_y=0.
- 16 block_switch pulses: rsp_gen wraps from 15 to 0.
- camera_y=63, rel_y=400: rsp_abs_y = (63*480+400) mod 65536 = 30640.
